// File: rtl/hamming_tx_scheduler_if.sv
// Requester and encoder-side signals of the Hamming(16,11) transmit scheduler.
// The slave modport is the scheduler view; the master modport is the requester/encoder view.
interface hamming_tx_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req_valid;
  logic [11*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                enc_bit;
  logic                enc_strobe;
  logic                enc_frame_start;
  logic                enc_tx_done;

  modport master (
    output req_valid, req_data, enc_tx_done,
    input  req_ready, enc_bit, enc_strobe, enc_frame_start
  );

  modport slave (
    input  req_valid, req_data, enc_tx_done,
    output req_ready, enc_bit, enc_strobe, enc_frame_start
  );
endinterface

// File: rtl/hamming_tx_scheduler.sv
// Round-robin arbiter feeding 16-bit Hamming frames serially to a shared encoder.
// Accept in T -> strobes T+1..T+16, then waits for tx_done (or timeout); req_ready only while idle.
module hamming_tx_scheduler #(
  parameter  int N_REQ      = 4,
  parameter  int TX_TIMEOUT = 255,
  localparam int IDW        = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hamming_tx_scheduler_if.slave bus,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_TX = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] last;
  logic [14:0]    frame;
  logic [3:0]     cnt;
  logic [15:0]    timer;
  logic           enc_bit;
  logic           enc_strobe;
  logic           enc_frame_start;

  logic [IDW-1:0] pick;
  logic           pick_vld;
  logic [IDW:0]   sum;
  logic           accept;
  logic [10:0]    pick_data;
  logic [15:0]    mapped;

  // Search starts one past the last grant and wraps modulo N_REQ.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N_REQ)) begin
        sum = sum - (IDW+1)'(N_REQ);
      end
      if (!pick_vld && bus.req_valid[sum[IDW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = sum[IDW-1:0];
      end
    end
  end

  assign accept    = (state == IDLE) && pick_vld;
  assign pick_data = bus.req_data[11*pick +: 11];

  // Data in non-power-of-two positions; parity slots 0,1,2,4,8 left at zero.
  assign mapped = {pick_data[10:4], 1'b0, pick_data[3:1], 1'b0, pick_data[0], 3'b000};

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[pick] = 1'b1;
    end
  end

  assign bus.enc_bit         = enc_bit;
  assign bus.enc_strobe      = enc_strobe;
  assign bus.enc_frame_start = enc_frame_start;

  // frame holds bits 15..1 still to be sent; bit 0 goes straight to enc_bit on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last            <= IDW'(N_REQ - 1);
      grant_id        <= '0;
      frame           <= '0;
      cnt             <= '0;
      timer           <= '0;
      enc_bit         <= 1'b0;
      enc_strobe      <= 1'b0;
      enc_frame_start <= 1'b0;
      timeout_err     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state           <= SHIFT;
            frame           <= mapped[15:1];
            grant_id        <= pick;
            last            <= pick;
            cnt             <= '0;
            enc_strobe      <= 1'b1;
            enc_bit         <= mapped[0];
            enc_frame_start <= 1'b1;
            busy            <= 1'b1;
          end
        end
        SHIFT: begin
          enc_frame_start <= 1'b0;
          if (cnt == 4'd15) begin
            state      <= WAIT_TX;
            cnt        <= '0;
            timer      <= '0;
            enc_strobe <= 1'b0;
            enc_bit    <= 1'b0;
          end else begin
            cnt     <= cnt + 4'd1;
            enc_bit <= frame[0];
            frame   <= {1'b0, frame[14:1]};
          end
        end
        WAIT_TX: begin
          // A done seen in the timeout cycle takes priority and suppresses the error.
          if (bus.enc_tx_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer == 16'(TX_TIMEOUT)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Directed bench for hamming_tx_scheduler: vector table plus arbitration, timeout and reset sequences.
module tb_hamming_tx_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] grant_id;
  logic       timeout_err;
  int         checks = 0;
  int         errors = 0;

  hamming_tx_scheduler_if #(.N_REQ(4)) bus ();

  hamming_tx_scheduler #(.N_REQ(4), .TX_TIMEOUT(255)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [10:0] data;
    int          grant;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at negedge+1 of an idle cycle; returns at negedge+1 of the first idle cycle after the frame.
  task automatic run_frame(input string tag, input logic [3:0] valid, input logic [10:0] data,
                           input int grant, input logic [15:0] exp_frame, input int done_at,
                           input logic [3:0] nxt_valid, input logic [3:0] nxt_ready);
    logic [15:0] got;
    bit          seen;
    bit          shift_ok;
    bit          err_seen;
    int          w;
    for (int i = 0; i < 4; i++) bus.req_data[11*i +: 11] = (i == grant) ? data : 11'h2AA;
    bus.req_valid = valid;
    #1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.req_ready != 4'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk({tag, "_accept_seen"}, 32'(seen), 32'd1);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(4'b1 << grant));
    @(posedge clk); #1;
    bus.req_valid = nxt_valid;
    got      = '0;
    shift_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      got[k] = bus.enc_bit;
      if (bus.enc_strobe !== 1'b1 || bus.enc_frame_start !== 1'(k == 0) || busy !== 1'b1 ||
          bus.req_ready !== 4'b0 || timeout_err !== 1'b0) shift_ok = 1'b0;
    end
    chk({tag, "_shift_ctrl"}, 32'(shift_ok), 32'd1);
    chk({tag, "_frame"}, 32'(got), 32'(exp_frame));
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(grant));
    @(negedge clk); #1;
    chk({tag, "_wait_entry"}, 32'({bus.enc_strobe, bus.enc_bit, busy}), 32'(3'b001));
    w        = 0;
    err_seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      bus.enc_tx_done = (w == done_at);
      @(negedge clk); #1;
      bus.enc_tx_done = 1'b0;
      w++;
      if (timeout_err) err_seen = 1'b1;
      if (!busy) break;
    end
    if (done_at < 0) begin
      chk({tag, "_wait_len"}, 32'(w), 32'd256);
      chk({tag, "_timeout_err"}, 32'(err_seen), 32'd1);
      chk({tag, "_ready_at_timeout"}, 32'(bus.req_ready), 32'(nxt_ready));
    end else begin
      chk({tag, "_wait_len"}, 32'(w), 32'(done_at + 1));
      chk({tag, "_no_timeout_err"}, 32'(err_seen), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n;
    int          cyc;
    int          prev;
    bit          seen;
    logic [15:0] got;

    vecs[0] = '{valid: 4'b0001, data: 11'h7FF, grant: 0, frame: 16'hFEE8};
    vecs[1] = '{valid: 4'b0001, data: 11'h001, grant: 0, frame: 16'h0008};
    vecs[2] = '{valid: 4'b1000, data: 11'h400, grant: 3, frame: 16'h8000};
    vecs[3] = '{valid: 4'b0100, data: 11'h000, grant: 2, frame: 16'h0000};
    vecs[4] = '{valid: 4'b1010, data: 11'h555, grant: 3, frame: 16'hAA48};
    vecs[5] = '{valid: 4'b1010, data: 11'h123, grant: 1, frame: 16'h2428};

    rst_n           = 1'b0;
    bus.req_valid   = '0;
    bus.req_data    = '0;
    bus.enc_tx_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(bus.enc_strobe), 32'd0);
    chk("rst_bit", 32'(bus.enc_bit), 32'd0);
    chk("rst_frame_start", 32'(bus.enc_frame_start), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // All requesters pending with done held high: strict rotation, one accept every 18 cycles.
    for (int i = 0; i < 4; i++) bus.req_data[11*i +: 11] = 11'(i + 1);
    bus.req_valid   = 4'hF;
    bus.enc_tx_done = 1'b1;
    #1;
    n    = 0;
    cyc  = 0;
    prev = 0;
    for (int c = 0; c < 200; c++) begin
      if (bus.req_ready != 4'b0) begin
        chk($sformatf("rr_grant%0d", n), 32'(bus.req_ready), 32'(4'b1 << (n % 4)));
        if (n > 0) chk($sformatf("rr_period%0d", n), 32'(cyc - prev), 32'd18);
        prev = cyc;
        n++;
        if (n == 6) begin
          @(posedge clk); #1;
          bus.req_valid = '0;
          break;
        end
      end
      @(negedge clk); #1;
      cyc++;
    end
    chk("rr_grant_count", 32'(n), 32'd6);
    repeat (20) @(negedge clk);
    #1;
    chk("rr_drain_busy", 32'(busy), 32'd0);
    bus.enc_tx_done = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].valid, vecs[v].data, vecs[v].grant,
                vecs[v].frame, 0, 4'b0000, 4'b0000);
    end

    // Done never comes; req2 waits and must be accepted in the timeout_err cycle.
    run_frame("timeout", 4'b0001, 11'h7FF, 0, 16'hFEE8, -1, 4'b0100, 4'b0100);
    chk("timeout_same_cycle_pulse", 32'(timeout_err), 32'd1);
    run_frame("done_at_limit", 4'b0100, 11'h001, 2, 16'h0008, 255, 4'b0000, 4'b0000);
    chk("done_at_limit_idle_err", 32'(timeout_err), 32'd0);

    // Reset while bit 7 of a frame for req1 is on the wire.
    bus.req_data  = '0;
    bus.req_valid = 4'b0010;
    #1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.req_ready != 4'b0) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    chk("midrst_ready", 32'(bus.req_ready), 32'(4'b0010));
    @(posedge clk); #1;
    bus.req_valid = '0;
    got = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      got[k] = bus.enc_strobe;
    end
    chk("midrst_pre_strobes", 32'(got), 32'h00FF);
    rst_n = 1'b0;
    #1;
    chk("midrst_strobe", 32'(bus.enc_strobe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grant_id", 32'(grant_id), 32'd0);
    chk("midrst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_frame("after_rst", 4'hF, 11'h7FF, 0, 16'hFEE8, 0, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
